// File: rtl/mem_responder_pkg.sv
// Shared constants and FSM state encoding for the mem_responder block.
`default_nettype none

package mem_pkg;
  localparam int ADDR_W = 12;
  localparam int DATA_W = 16;
  localparam int DEPTH  = 1 << ADDR_W;

  localparam logic [ADDR_W-1:0] IO_BASE = 12'hFF0;

  localparam logic [3:0] IO_OUT   = 4'd0;
  localparam logic [3:0] IO_IN    = 4'd1;
  localparam logic [3:0] IO_RDCNT = 4'd2;
  localparam logic [3:0] IO_WRCNT = 4'd3;

  typedef enum logic [1:0] {
    SERVE = 2'd0,
    LOAD  = 2'd1,
    DONE  = 2'd2
  } state_t;
endpackage

`default_nettype wire

// File: rtl/mem_responder_if.sv
// Processor bus, loader stream and board I/O bundle for mem_responder.
`default_nettype none

interface mem_responder_if;
  import mem_pkg::*;

  logic [ADDR_W-1:0] m_addr;
  logic              m_rw;
  logic [DATA_W-1:0] m_data;
  logic [DATA_W-1:0] m_q;
  logic              load_start;
  logic              load_valid;
  logic [DATA_W-1:0] load_data;
  logic              load_last;
  logic              load_ready;
  logic              load_done;
  logic [DATA_W-1:0] io_in;
  logic [DATA_W-1:0] io_out;
  logic              io_out_stb;

  modport master (
    output m_addr, m_rw, m_data, load_start, load_valid, load_data, load_last, io_in,
    input  m_q, load_ready, load_done, io_out, io_out_stb
  );

  modport slave (
    input  m_addr, m_rw, m_data, load_start, load_valid, load_data, load_last, io_in,
    output m_q, load_ready, load_done, io_out, io_out_stb
  );
endinterface

`default_nettype wire

// File: rtl/mem_responder_array.sv
// Single-port synchronous word RAM; a read returns the contents before any same-cycle write.
`default_nettype none

module mem_array
  import mem_pkg::*;
(
  input  wire logic              clk,
  input  wire logic              i_we,
  input  wire logic              i_re,
  input  wire logic [ADDR_W-1:0] i_addr,
  input  wire logic [DATA_W-1:0] i_wdata,
  output logic      [DATA_W-1:0] o_rdata
);
  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DATA_W-1:0] r_rdata;

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_addr] <= i_wdata;
    if (i_re) r_rdata <= r_mem[i_addr];
  end

  assign o_rdata = r_rdata;
endmodule

`default_nettype wire

// File: rtl/mem_responder.sv
// Memory responder: RAM + I/O window for the processor, with a streaming preload port.
// Optional access counters at IO_BASE+2/+3 are enabled by defining MEM_ACCESS_CNT_EN.
`default_nettype none

module mem_responder
  import mem_pkg::*;
(
  input  wire logic      clock,
  input  wire logic      reset,
  mem_responder_if.slave bus
);
  state_t            r_state, w_next;
  logic [ADDR_W-1:0] r_cnt;
  logic              r_sel_ram;
  logic [DATA_W-1:0] r_mq_io;
  logic [DATA_W-1:0] r_io_out;
  logic              r_io_stb;
  logic [DATA_W-1:0] r_sync1, r_sync2;

  logic              w_ram_we, w_ram_re, w_cpu_rd, w_cpu_wr, w_load_acc;
  logic [ADDR_W-1:0] w_ram_addr;
  logic [DATA_W-1:0] w_ram_wdata, w_ram_q, w_io_rdata;
  logic              w_in_win;
  logic [3:0]        w_off;

  assign w_in_win = (bus.m_addr[ADDR_W-1:4] == IO_BASE[ADDR_W-1:4]);
  assign w_off    = bus.m_addr[3:0];

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) r_state <= SERVE;
    else        r_state <= w_next;
  end

  // The single RAM port belongs to the processor in SERVE and to the loader in LOAD.
  always_comb begin
    w_next      = r_state;
    w_ram_we    = 1'b0;
    w_ram_re    = 1'b0;
    w_ram_addr  = bus.m_addr;
    w_ram_wdata = bus.m_data;
    w_cpu_rd    = 1'b0;
    w_cpu_wr    = 1'b0;
    w_load_acc  = 1'b0;
    case (r_state)
      SERVE: begin
        w_cpu_rd = !bus.m_rw;
        w_cpu_wr = bus.m_rw;
        w_ram_we = bus.m_rw && !w_in_win;
        w_ram_re = !bus.m_rw && !w_in_win;
        if (bus.load_start) w_next = LOAD;
      end
      LOAD: begin
        w_load_acc  = bus.load_valid;
        w_ram_addr  = r_cnt;
        w_ram_wdata = bus.load_data;
        w_ram_we    = bus.load_valid;
        if (bus.load_valid && (bus.load_last || (&r_cnt))) w_next = DONE;
      end
      DONE:    w_next = SERVE;
      default: w_next = SERVE;
    endcase
  end

  mem_array u_array (
    .clk     (clock),
    .i_we    (w_ram_we),
    .i_re    (w_ram_re),
    .i_addr  (w_ram_addr),
    .i_wdata (w_ram_wdata),
    .o_rdata (w_ram_q)
  );

`ifdef MEM_ACCESS_CNT_EN
  logic [DATA_W-1:0] r_rd_cnt, r_wr_cnt;
  logic              w_cnt_clr;

  assign w_cnt_clr = w_cpu_wr && w_in_win && (w_off == IO_RDCNT);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_rd_cnt <= '0;
      r_wr_cnt <= '0;
    end else if (w_cnt_clr) begin
      r_rd_cnt <= '0;
      r_wr_cnt <= '0;
    end else begin
      if (w_cpu_rd && !(&r_rd_cnt)) r_rd_cnt <= r_rd_cnt + 1'b1;
      if (w_cpu_wr && !(&r_wr_cnt)) r_wr_cnt <= r_wr_cnt + 1'b1;
    end
  end
`endif

  always_comb begin
    w_io_rdata = '0;
    case (w_off)
      IO_OUT:   w_io_rdata = r_io_out;
      IO_IN:    w_io_rdata = r_sync2;
`ifdef MEM_ACCESS_CNT_EN
      IO_RDCNT: w_io_rdata = r_rd_cnt;
      IO_WRCNT: w_io_rdata = r_wr_cnt;
`endif
      default:  w_io_rdata = '0;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_cnt     <= '0;
      r_sel_ram <= 1'b0;
      r_mq_io   <= '0;
      r_io_out  <= '0;
      r_io_stb  <= 1'b0;
      r_sync1   <= '0;
      r_sync2   <= '0;
    end else begin
      r_sync1  <= bus.io_in;
      r_sync2  <= r_sync1;
      r_io_stb <= w_cpu_wr && w_in_win && (w_off == IO_OUT);
      if (w_cpu_wr && w_in_win && (w_off == IO_OUT)) r_io_out <= bus.m_data;
      if (r_state == SERVE && bus.load_start) r_cnt <= '0;
      else if (w_load_acc)                    r_cnt <= r_cnt + 1'b1;
      // m_q is either the RAM output register or a captured I/O value; it only moves on reads.
      if (w_cpu_rd) begin
        r_sel_ram <= !w_in_win;
        r_mq_io   <= w_io_rdata;
      end else if (r_state == LOAD && !bus.m_rw) begin
        r_sel_ram <= 1'b0;
        r_mq_io   <= '0;
      end
    end
  end

  assign bus.m_q        = r_sel_ram ? w_ram_q : r_mq_io;
  assign bus.io_out     = r_io_out;
  assign bus.io_out_stb = r_io_stb;
  assign bus.load_ready = (r_state == LOAD);
  assign bus.load_done  = (r_state == DONE);
endmodule

`default_nettype wire

// File: tb/tb_mem_responder.sv
// Directed self-checking bench for mem_responder.
`default_nettype none

module tb_mem_responder;
  import mem_pkg::*;

  logic clock = 1'b0;
  logic reset = 1'b0;
  int   tests = 0;
  int   fails = 0;

  mem_responder_if bus ();

  mem_responder dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic rd(input logic [ADDR_W-1:0] a);
    bus.m_addr = a;
    bus.m_rw   = 1'b0;
    tick();
  endtask

  task automatic wr(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    bus.m_addr = a;
    bus.m_rw   = 1'b1;
    bus.m_data = d;
    tick();
    bus.m_rw   = 1'b0;
  endtask

  task automatic test_reset();
    bus.m_addr = '0; bus.m_rw = 1'b0; bus.m_data = '0;
    bus.load_start = 1'b0; bus.load_valid = 1'b0; bus.load_data = '0; bus.load_last = 1'b0;
    bus.io_in = '0;
    #12;
    tests++;
    if (bus.m_q !== 16'h0 || bus.io_out !== 16'h0 || bus.io_out_stb !== 1'b0 ||
        bus.load_ready !== 1'b0 || bus.load_done !== 1'b0) begin
      fails++;
      $display("FAIL reset_outputs: got q=%h io=%h stb=%b rdy=%b done=%b want all 0",
               bus.m_q, bus.io_out, bus.io_out_stb, bus.load_ready, bus.load_done);
    end
    tick();
    reset = 1'b1;
    tick();
  endtask

  task automatic test_load();
    logic [DATA_W-1:0] w [3];
    w[0] = 16'h8001; w[1] = 16'h1234; w[2] = 16'hBEEF;
    bus.load_start = 1'b1;
    tick();
    bus.load_start = 1'b0;
    tests++;
    if (bus.load_ready !== 1'b1) begin
      fails++; $display("FAIL load_ready: got %b want 1", bus.load_ready);
    end
    for (int i = 0; i < 3; i++) begin
      bus.load_valid = 1'b1;
      bus.load_data  = w[i];
      bus.load_last  = (i == 2);
      tick();
    end
    bus.load_valid = 1'b0; bus.load_last = 1'b0;
    tests++;
    if (bus.load_done !== 1'b1 || bus.load_ready !== 1'b0) begin
      fails++; $display("FAIL load_done_pulse: got done=%b rdy=%b want 1,0", bus.load_done, bus.load_ready);
    end
    tick();
    tests++;
    if (bus.load_done !== 1'b0) begin
      fails++; $display("FAIL load_done_single: got %b want 0", bus.load_done);
    end
    for (int i = 0; i < 3; i++) begin
      rd(ADDR_W'(i));
      tests++;
      if (bus.m_q !== w[i]) begin
        fails++; $display("FAIL load_read%0d: got %h want %h", i, bus.m_q, w[i]);
      end
    end
  endtask

  task automatic test_rw();
    wr(12'h010, 16'hA5A5);
    rd(12'h010);
    tests++;
    if (bus.m_q !== 16'hA5A5) begin
      fails++; $display("FAIL rw_read: got %h want A5A5", bus.m_q);
    end
    wr(12'h010, 16'h0000);
    tests++;
    if (bus.m_q !== 16'hA5A5) begin
      fails++; $display("FAIL rw_old_data: got %h want A5A5", bus.m_q);
    end
    rd(12'h010);
    tests++;
    if (bus.m_q !== 16'h0000) begin
      fails++; $display("FAIL rw_new_data: got %h want 0000", bus.m_q);
    end
  endtask

  task automatic test_io();
    wr(IO_BASE, 16'h00FF);
    tests++;
    if (bus.io_out !== 16'h00FF || bus.io_out_stb !== 1'b1 || bus.m_q !== 16'h0000) begin
      fails++; $display("FAIL io_write: got io=%h stb=%b q=%h want 00FF,1,0000",
                        bus.io_out, bus.io_out_stb, bus.m_q);
    end
    rd(IO_BASE);
    tests++;
    if (bus.io_out_stb !== 1'b0 || bus.m_q !== 16'h00FF) begin
      fails++; $display("FAIL io_readback: got stb=%b q=%h want 0,00FF", bus.io_out_stb, bus.m_q);
    end
    bus.io_in = 16'h0003;
    bus.m_addr = IO_BASE + 12'd1;
    tick(); tick(); tick();
    tests++;
    if (bus.m_q !== 16'h0003) begin
      fails++; $display("FAIL io_in_sync: got %h want 0003", bus.m_q);
    end
    wr(IO_BASE + 12'd1, 16'hFFFF);
    wr(IO_BASE + 12'd5, 16'h1234);
    rd(IO_BASE + 12'd5);
    tests++;
    if (bus.m_q !== 16'h0000 || bus.io_out !== 16'h00FF) begin
      fails++; $display("FAIL io_unmapped: got q=%h io=%h want 0000,00FF", bus.m_q, bus.io_out);
    end
  endtask

  task automatic test_lockout();
    wr(12'h020, 16'h1111);
    rd(12'h020);
    tests++;
    if (bus.m_q !== 16'h1111) begin
      fails++; $display("FAIL lock_pre: got %h want 1111", bus.m_q);
    end
    bus.load_start = 1'b1;
    tick();
    bus.load_start = 1'b0;
    rd(12'h000);
    tests++;
    if (bus.m_q !== 16'h0000) begin
      fails++; $display("FAIL lock_read_zero: got %h want 0000", bus.m_q);
    end
    wr(12'h020, 16'h7777);
    bus.load_valid = 1'b1; bus.load_data = 16'h8001; bus.load_last = 1'b1;
    tick();
    bus.load_valid = 1'b0; bus.load_last = 1'b0;
    tick();
    rd(12'h020);
    tests++;
    if (bus.m_q !== 16'h1111) begin
      fails++; $display("FAIL lock_write_dropped: got %h want 1111", bus.m_q);
    end
  endtask

  task automatic test_full_load();
    bus.load_start = 1'b1;
    tick();
    bus.load_start = 1'b0;
    bus.load_valid = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      bus.load_data = (i == 0) ? 16'hC0DE : 16'(i);
      if (i == DEPTH - 1) begin
        tests++;
        if (bus.load_done !== 1'b0 || bus.load_ready !== 1'b1) begin
          fails++; $display("FAIL full_early_done: got done=%b rdy=%b want 0,1", bus.load_done, bus.load_ready);
        end
      end
      tick();
    end
    tests++;
    if (bus.load_done !== 1'b1) begin
      fails++; $display("FAIL full_done: got %b want 1", bus.load_done);
    end
    tick();
    bus.load_valid = 1'b0;
    tick();
    rd(12'h000);
    tests++;
    if (bus.m_q !== 16'hC0DE) begin
      fails++; $display("FAIL full_addr0: got %h want C0DE", bus.m_q);
    end
    rd(12'hFEF);
    tests++;
    if (bus.m_q !== 16'h0FEF) begin
      fails++; $display("FAIL full_addrFEF: got %h want 0FEF", bus.m_q);
    end
  endtask

  task automatic test_reset_mid_load();
    int done_seen = 0;
    bus.load_start = 1'b1;
    tick();
    bus.load_start = 1'b0;
    bus.load_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      bus.load_data = 16'h0100 + 16'(i);
      tick();
    end
    reset = 1'b0;
    #1;
    tests++;
    if (bus.load_ready !== 1'b0 || bus.io_out !== 16'h0000 || bus.m_q !== 16'h0000) begin
      fails++; $display("FAIL rst_async: got rdy=%b io=%h q=%h want 0,0000,0000",
                        bus.load_ready, bus.io_out, bus.m_q);
    end
    tick();
    reset = 1'b1;
    bus.load_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (bus.load_done !== 1'b0 || bus.load_ready !== 1'b0) done_seen++;
    end
    tests++;
    if (done_seen != 0) begin
      fails++; $display("FAIL rst_no_done: got %0d cycles with done/ready high want 0", done_seen);
    end
    for (int i = 0; i < 5; i++) begin
      rd(ADDR_W'(i));
      tests++;
      if (bus.m_q !== 16'h0100 + 16'(i)) begin
        fails++; $display("FAIL rst_word%0d: got %h want %h", i, bus.m_q, 16'h0100 + 16'(i));
      end
    end
  endtask

`ifdef MEM_ACCESS_CNT_EN
  task automatic test_counters();
    wr(IO_BASE + 12'd2, 16'h0000);
    rd(12'h010);
    rd(12'h011);
    wr(12'h030, 16'h5555);
    rd(IO_BASE + 12'd2);
    tests++;
    if (bus.m_q !== 16'd2) begin
      fails++; $display("FAIL cnt_rd: got %h want 0002", bus.m_q);
    end
    rd(IO_BASE + 12'd3);
    tests++;
    if (bus.m_q !== 16'd1) begin
      fails++; $display("FAIL cnt_wr: got %h want 0001", bus.m_q);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_load();
    test_rw();
    test_io();
    test_lockout();
    test_full_load();
    test_reset_mid_load();
`ifdef MEM_ACCESS_CNT_EN
    test_counters();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got no completion want finish before 2ms");
    $fatal(1);
  end
endmodule

`default_nettype wire
